// File: rtl/nn_pkg.sv
// nn_pkg: shared FSM states, FP32 constants and PE header payload layout for the layer sequencer
package nn_pkg;
  localparam int CNT_W = 10;
  localparam logic [31:0] FP32_ZERO = 32'h0000_0000;
  typedef enum logic [2:0] {IDLE, HEAD, STREAM, WAIT, WRITE, FIN} state_t;
  typedef struct packed {
    logic [31-CNT_W:0] rsvd;
    logic [CNT_W-1:0]  n;
  } head_t;
  function automatic logic [31:0] head_word(input logic [CNT_W-1:0] n);
    head_t h;
    h.rsvd = '0;
    h.n = n;
    return h;
  endfunction
endpackage

// File: rtl/pe_layer_sequencer_if.sv
// pe_layer_sequencer_if: memory, PE and output-buffer bus between the sequencer (master) and datapath (slave)
//   w/x/b_addr, w/x/b_rdata : synchronous memory reads (data one cycle after address)
//   pe_w/x/b, pe_head, pe_count, pe_out, pe_done : PE operand stream and result
//   out_we, out_addr, out_data : output activation buffer write port
interface pe_layer_sequencer_if import nn_pkg::*; #(parameter int WA_W = 17);
  logic [WA_W-1:0]  w_addr;
  logic [CNT_W-1:0] x_addr;
  logic [7:0]       b_addr;
  logic [31:0]      w_rdata, x_rdata, b_rdata;
  logic [31:0]      pe_w, pe_x, pe_b, pe_out;
  logic             pe_head, pe_done;
  logic [CNT_W-1:0] pe_count;
  logic             out_we;
  logic [7:0]       out_addr;
  logic [31:0]      out_data;
  modport master (
    output w_addr, x_addr, b_addr, pe_w, pe_x, pe_b, pe_head, pe_count, out_we, out_addr, out_data,
    input  w_rdata, x_rdata, b_rdata, pe_out, pe_done
  );
  modport slave (
    input  w_addr, x_addr, b_addr, pe_w, pe_x, pe_b, pe_head, pe_count, out_we, out_addr, out_data,
    output w_rdata, x_rdata, b_rdata, pe_out, pe_done
  );
endinterface

// File: rtl/seq_addr_gen.sv
// seq_addr_gen: neuron (j) and stream (k) counters plus running weight/input read addresses
//   load : start of layer, clears everything; advance : next neuron, base += n
//   in_head/in_stream : current FSM phase; j doubles as bias address and output address
module seq_addr_gen import nn_pkg::*; #(parameter int WA_W = 17) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             advance,
  input  logic             in_head,
  input  logic             in_stream,
  input  logic [CNT_W-1:0] n,
  output logic [7:0]       j,
  output logic [CNT_W-1:0] k,
  output logic [CNT_W-1:0] x_addr,
  output logic [WA_W-1:0]  w_addr
);
  logic [WA_W-1:0] base, nxt_base;
  assign nxt_base = base + WA_W'(n);
  // Addresses run one ahead of k so read data lines up with stream index k
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      j <= '0;
      k <= '0;
      x_addr <= '0;
      w_addr <= '0;
      base <= '0;
    end else begin
      if (load) begin
        j <= '0;
        base <= '0;
        w_addr <= '0;
        x_addr <= '0;
      end else if (advance) begin
        j <= j + 8'd1;
        base <= nxt_base;
        w_addr <= nxt_base;
        x_addr <= '0;
      end else if (in_head || in_stream) begin
        w_addr <= w_addr + WA_W'(1);
        x_addr <= x_addr + CNT_W'(1);
      end
      k <= in_head ? '0 : in_stream ? k + CNT_W'(1) : k;
    end
endmodule

// File: rtl/pe_layer_sequencer.sv
// pe_layer_sequencer: steps one PE through every neuron of a fully connected layer
//   clock/reset : clock, async active-high reset
//   start, cfg_n_inputs, cfg_n_neurons : layer launch and size
//   busy, done, err : status; done/err are one-cycle pulses
//   bus : memory reads, PE operand stream and output buffer writes
module pe_layer_sequencer import nn_pkg::*; #(
  parameter int N_MAX   = 784,
  parameter int M_MAX   = 128,
  parameter int WA_W    = 17,
  parameter int TIMEOUT = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] cfg_n_inputs,
  input  logic [7:0]       cfg_n_neurons,
  output logic             busy,
  output logic             done,
  output logic             err,
  pe_layer_sequencer_if.master bus
);
  localparam int TW = $clog2(TIMEOUT + 1);
  state_t state, nxt;
  logic [CNT_W-1:0] n_r, k, x_addr;
  logic [7:0] m_r, j;
  logic [WA_W-1:0] w_addr;
  logic [TW-1:0] wait_cnt;
  logic [31:0] pe_b;
  logic err_n, load, advance, bad;
  assign bad = cfg_n_inputs == '0 || cfg_n_inputs > CNT_W'(N_MAX) ||
               cfg_n_neurons == '0 || cfg_n_neurons > 8'(M_MAX);
  seq_addr_gen #(.WA_W(WA_W)) u_addr (
    .clock(clock), .reset(reset), .load(load), .advance(advance),
    .in_head(state == HEAD), .in_stream(state == STREAM), .n(n_r),
    .j(j), .k(k), .x_addr(x_addr), .w_addr(w_addr)
  );
  always_comb begin
    nxt = state;
    err_n = 1'b0;
    load = 1'b0;
    advance = 1'b0;
    case (state)
      IDLE: if (start) begin
        err_n = bad;
        load = !bad;
        nxt = bad ? IDLE : HEAD;
      end
      HEAD: nxt = STREAM;
      STREAM: nxt = (k == n_r - CNT_W'(1)) ? WAIT : STREAM;
      WAIT: if (bus.pe_done) nxt = WRITE;
        else if (wait_cnt == TW'(TIMEOUT - 1)) begin
          err_n = 1'b1;
          nxt = IDLE;
        end
      WRITE: begin
        advance = j != m_r - 8'd1;
        nxt = advance ? HEAD : FIN;
      end
      FIN: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= IDLE;
      n_r <= '0;
      m_r <= '0;
      wait_cnt <= '0;
      pe_b <= FP32_ZERO;
      err <= 1'b0;
    end else begin
      state <= nxt;
      err <= err_n;
      if (load) begin
        n_r <= cfg_n_inputs;
        m_r <= cfg_n_neurons;
      end
      wait_cnt <= (state == WAIT) ? wait_cnt + TW'(1) : '0;
      // Bias read issued in HEAD lands during the first STREAM cycle
      if (state == STREAM && k == '0) pe_b <= bus.b_rdata;
    end
  assign busy = state != IDLE;
  assign done = state == FIN;
  assign bus.w_addr = w_addr;
  assign bus.x_addr = x_addr;
  assign bus.b_addr = j;
  assign bus.pe_head = state == HEAD;
  assign bus.pe_w = (state == STREAM) ? bus.w_rdata : FP32_ZERO;
  assign bus.pe_x = (state == HEAD) ? head_word(n_r) : (state == STREAM) ? bus.x_rdata : FP32_ZERO;
  assign bus.pe_count = (state == STREAM) ? k : '0;
  assign bus.pe_b = pe_b;
  assign bus.out_we = state == WRITE;
  assign bus.out_addr = (state == WRITE) ? j : '0;
  assign bus.out_data = (state == WRITE) ? bus.pe_out : FP32_ZERO;
endmodule
